// File: rtl/wb_arb_pkg.sv
// ---------------------------------------------------------------------------
// wb_arb_pkg
// Shared types and constants for the WISHBONE memory-port arbiter.
//   arb_state_t : arbiter FSM state encoding
//   CTI_*       : WISHBONE cycle type identifier codes
//   AW_DEF/DW_DEF : default address/data widths
// ---------------------------------------------------------------------------
package wb_arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2,
    TOUT = 2'd3
  } arb_state_t;

endpackage

// File: rtl/wb_arb_watchdog.sv
// ---------------------------------------------------------------------------
// wb_arb_watchdog
// Counts consecutive cycles in which a strobe is outstanding without a slave
// response and flags expiry so the arbiter can terminate a hung access.
// Ports:
//   wb_clk, wb_rst : clock and synchronous active-high reset
//   stb            : strobe currently presented to the slave
//   ack, err       : slave responses (either one ends the wait)
//   expire         : high in the wait cycle whose count reaches TIMEOUT-1
// ---------------------------------------------------------------------------
module wb_arb_watchdog #(
  parameter int TIMEOUT = 256
) (
  input  logic wb_clk,
  input  logic wb_rst,
  input  logic stb,
  input  logic ack,
  input  logic err,
  output logic expire
);

  // Expiry is flagged on the wait cycle that moves the count to TIMEOUT-1,
  // so the arbiter enters its timeout state on that same edge.
  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 2);

  logic [15:0] cnt_reg;
  logic        waiting;

  assign waiting = stb && !ack && !err;
  // A response in the expiry cycle deasserts waiting, so the response wins.
  assign expire  = waiting && (cnt_reg == LIMIT);

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      cnt_reg <= '0;
    end else if (waiting) begin
      cnt_reg <= cnt_reg + 16'd1;
    end else begin
      cnt_reg <= '0;
    end
  end

endmodule

// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// wb_mem_arbiter
// Two-master WISHBONE arbiter for the MAC memory port. Requester 0 is RX DMA
// write-back, requester 1 is TX DMA fetch. A grant lasts a full cyc-high
// cycle so bursts are never split; ties go to the requester not served last.
// A watchdog terminates a hung access with an error and a tout_o pulse.
// Ports:
//   wb_clk, wb_rst          : clock, synchronous active-high reset
//   m0_* / m1_* inputs      : requester address/sel/we/data/cyc/stb/cti/bte
//   m0_dat_o / m1_dat_o     : read data, straight from s_dat_i
//   m0_ack_o/err_o, m1_...  : responses, routed to the current owner only
//   s_* outputs             : memory-side master signals of the owner
//   s_dat_i/ack_i/err_i     : memory-side responses
//   gnt_o                   : one-hot current owner, 00 when idle
//   tout_o                  : one-cycle pulse when the watchdog fires
// ---------------------------------------------------------------------------
module wb_mem_arbiter
  import wb_arb_pkg::*;
#(
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 256
) (
  input  logic            wb_clk,
  input  logic            wb_rst,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic [DW-1:0]   s_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  output logic [1:0]      gnt_o,
  output logic            tout_o
);

  arb_state_t state_reg;
  logic       last_reg;   // requester served most recently
  logic       tout_reg;   // high only in the first timeout cycle
  logic       expire;

  wb_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .stb    (s_stb_o),
    .ack    (s_ack_i),
    .err    (s_err_i),
    .expire (expire)
  );

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
  assign tout_o   = tout_reg;

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
      tout_reg  <= 1'b0;
    end else begin
      tout_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_reg)) begin
            state_reg <= GNT0;
          end else if (m1_cyc_i) begin
            state_reg <= GNT1;
          end
        end
        GNT0: begin
          last_reg <= 1'b0;
          // Owner leaving takes precedence: hand straight over if m1 waits.
          if (!m0_cyc_i) begin
            state_reg <= m1_cyc_i ? GNT1 : IDLE;
          end else if (expire) begin
            state_reg <= TOUT;
            tout_reg  <= 1'b1;
          end
        end
        GNT1: begin
          last_reg <= 1'b1;
          if (!m1_cyc_i) begin
            state_reg <= m0_cyc_i ? GNT0 : IDLE;
          end else if (expire) begin
            state_reg <= TOUT;
            tout_reg  <= 1'b1;
          end
        end
        TOUT: begin
          // last_reg still names the timed-out owner; wait for it to let go.
          if (!(last_reg ? m1_cyc_i : m0_cyc_i)) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Zero-latency data path: the owner's bus is muxed straight through.
  always_comb begin
    s_adr_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_dat_o  = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    gnt_o    = 2'b00;
    case (state_reg)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_dat_o  = m0_dat_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i;
        gnt_o    = 2'b01;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_dat_o  = m1_dat_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i;
        gnt_o    = 2'b10;
      end
      TOUT: begin
        // Slave is cut off; only the synthesized error reaches the owner.
        m0_err_o = tout_reg && !last_reg;
        m1_err_o = tout_reg && last_reg;
        gnt_o    = last_reg ? 2'b10 : 2'b01;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_wb_mem_arbiter;
  import wb_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          wb_clk = 1'b0;
  logic          wb_rst;
  logic [AW-1:0] m0_adr_i, m1_adr_i;
  logic [SW-1:0] m0_sel_i, m1_sel_i;
  logic          m0_we_i, m1_we_i;
  logic [DW-1:0] m0_dat_i, m1_dat_i;
  logic          m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
  logic [2:0]    m0_cti_i, m1_cti_i;
  logic [1:0]    m0_bte_i, m1_bte_i;
  logic [DW-1:0] m0_dat_o, m1_dat_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [AW-1:0] s_adr_o;
  logic [SW-1:0] s_sel_o;
  logic          s_we_o;
  logic [DW-1:0] s_dat_o;
  logic          s_cyc_o, s_stb_o;
  logic [2:0]    s_cti_o;
  logic [1:0]    s_bte_o;
  logic [DW-1:0] s_dat_i;
  logic          s_ack_i, s_err_i;
  logic [1:0]    gnt_o;
  logic          tout_o;

  always #5 wb_clk = ~wb_clk;

  wb_mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m0_adr_i(m0_adr_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i), .m0_dat_i(m0_dat_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m1_adr_i(m1_adr_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i), .m1_dat_i(m1_dat_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_dat_o(s_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .gnt_o(gnt_o), .tout_o(tout_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard entry: who should see the response, with what data and kind.
  typedef struct {
    int            who;
    logic [DW-1:0] dat;
    logic          err;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    int            who;
    logic [AW-1:0] adr;
    logic          we;
    logic [DW-1:0] wdat;
    logic [SW-1:0] sel;
    int            delay;
    logic          err;
    logic [DW-1:0] rdat;
    logic [1:0]    exp_gnt;
  } vec_t;
  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic set_m(input int who, input logic cyc, input logic stb,
                       input logic [AW-1:0] adr, input logic we, input logic [DW-1:0] dat,
                       input logic [SW-1:0] sel, input logic [2:0] cti, input logic [1:0] bte);
    if (who == 0) begin
      m0_cyc_i = cyc; m0_stb_i = stb; m0_adr_i = adr; m0_we_i = we;
      m0_dat_i = dat; m0_sel_i = sel; m0_cti_i = cti; m0_bte_i = bte;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = stb; m1_adr_i = adr; m1_we_i = we;
      m1_dat_i = dat; m1_sel_i = sel; m1_cti_i = cti; m1_bte_i = bte;
    end
  endtask

  task automatic release_m(input int who);
    set_m(who, 1'b0, 1'b0, '0, 1'b0, '0, '0, 3'b000, 2'b00);
  endtask

  // Slave answers the oldest expected transfer; the DUT must route it.
  task automatic respond();
    sb_t  e;
    logic got0, got1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got empty queue required one entry");
      return;
    end
    e = sb.pop_front();
    s_dat_i = e.dat;
    if (e.err) s_err_i = 1'b1;
    else       s_ack_i = 1'b1;
    #1;
    got0 = m0_ack_o | m0_err_o;
    got1 = m1_ack_o | m1_err_o;
    chk("resp_m0", got0, e.who == 0);
    chk("resp_m1", got1, e.who == 1);
    chk("resp_err", m0_err_o | m1_err_o, e.err);
    chk("resp_data", (e.who == 0) ? m0_dat_o : m1_dat_o, e.dat);
    $display("xfer: m%0d %s data=%h", e.who, e.err ? "err" : "ack", e.dat);
    tick();
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    set_m(v.who, 1'b1, 1'b1, v.adr, v.we, v.wdat, v.sel, CTI_CLASSIC, 2'b00);
    sb.push_back('{v.who, v.rdat, v.err});
    #1;
    chk("pre_grant_cyc", s_cyc_o, 1'b0);
    tick();
    chk("gnt", gnt_o, v.exp_gnt);
    chk("s_cyc", s_cyc_o, 1'b1);
    chk("s_stb", s_stb_o, 1'b1);
    chk("s_adr", s_adr_o, v.adr);
    chk("s_we", s_we_o, v.we);
    chk("s_dat_o", s_dat_o, v.wdat);
    chk("s_sel", s_sel_o, v.sel);
    for (int k = 0; k < v.delay; k++) begin
      chk("wait_noresp", m0_ack_o | m1_ack_o | m0_err_o | m1_err_o, 1'b0);
      tick();
    end
    respond();
    release_m(v.who);
    tick();
    chk("vec_idle_gnt", gnt_o, 2'b00);
    chk("vec_idle_cyc", s_cyc_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish required finish before 200us");
    $fatal(1, "time limit");
  end

  initial begin
    wb_rst = 1'b1;
    release_m(0);
    release_m(1);
    s_dat_i = 32'hA5A5_5A5A;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;

    vecs[0] = '{0, 32'h0000_0100, 1'b0, 32'h0,         4'hF, 3, 1'b0, 32'hDEAD_0001, 2'b01};
    vecs[1] = '{1, 32'h0000_0200, 1'b1, 32'h1122_3344, 4'h3, 0, 1'b0, 32'h0000_0000, 2'b10};
    vecs[2] = '{0, 32'h0000_0304, 1'b1, 32'h5566_7788, 4'hC, 1, 1'b1, 32'h0000_0000, 2'b01};
    vecs[3] = '{1, 32'h0000_040C, 1'b0, 32'h0,         4'hF, 5, 1'b0, 32'hCAFE_F00D, 2'b10};

    // Reset state
    tick();
    tick();
    chk("rst_s_cyc", s_cyc_o, 1'b0);
    chk("rst_s_stb", s_stb_o, 1'b0);
    chk("rst_s_adr", s_adr_o, 32'h0);
    chk("rst_gnt", gnt_o, 2'b00);
    chk("rst_tout", tout_o, 1'b0);
    chk("rst_m0_ack", m0_ack_o, 1'b0);
    chk("rst_m0_dat", m0_dat_o, 32'hA5A5_5A5A);
    chk("rst_m1_dat", m1_dat_o, 32'hA5A5_5A5A);
    wb_rst = 1'b0;
    tick();

    // Single transfers from the table
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Tie after m1 served: m0 first, then m1 back-to-back
    set_m(0, 1'b1, 1'b1, 32'h500, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    set_m(1, 1'b1, 1'b1, 32'h600, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    sb.push_back('{0, 32'h1111_0000, 1'b0});
    sb.push_back('{1, 32'h2222_0000, 1'b0});
    tick();
    chk("tie1_gnt", gnt_o, 2'b01);
    chk("tie1_adr", s_adr_o, 32'h500);
    respond();
    release_m(0);
    #1;
    chk("handover_cyc_low", s_cyc_o, 1'b0);
    tick();
    chk("b2b_gnt", gnt_o, 2'b10);
    chk("b2b_adr", s_adr_o, 32'h600);
    respond();
    release_m(1);
    tick();
    chk("tie1_idle", gnt_o, 2'b00);

    // Tie after m1 served again: m0 wins
    set_m(0, 1'b1, 1'b1, 32'h510, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    set_m(1, 1'b1, 1'b1, 32'h610, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    sb.push_back('{0, 32'h1111_0001, 1'b0});
    tick();
    chk("tie2_gnt", gnt_o, 2'b01);
    respond();
    release_m(0);
    release_m(1);
    tick();
    chk("tie2_idle", gnt_o, 2'b00);

    // Tie after m0 served: m1 wins and runs a 4-beat burst while m0 waits
    set_m(0, 1'b1, 1'b1, 32'h700, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    set_m(1, 1'b1, 1'b1, 32'h800, 1'b0, '0, 4'hF, CTI_INCR, 2'b01);
    tick();
    chk("burst_gnt", gnt_o, 2'b10);
    for (int b = 0; b < 4; b++) begin
      set_m(1, 1'b1, 1'b1, 32'h800 + 32'(4 * b), 1'b0, '0, 4'hF,
            (b == 3) ? CTI_EOB : CTI_INCR, 2'b01);
      sb.push_back('{1, 32'hB000_0000 + 32'(b), 1'b0});
      #1;
      chk("burst_hold_gnt", gnt_o, 2'b10);
      chk("burst_adr", s_adr_o, 32'h800 + 32'(4 * b));
      chk("burst_cti", s_cti_o, (b == 3) ? CTI_EOB : CTI_INCR);
      chk("burst_bte", s_bte_o, 2'b01);
      respond();
    end
    release_m(1);
    #1;
    chk("burst_end_gnt", gnt_o, 2'b10);
    tick();
    chk("burst_m0_gnt", gnt_o, 2'b01);
    chk("burst_m0_adr", s_adr_o, 32'h700);
    sb.push_back('{0, 32'h3333_0000, 1'b0});
    respond();
    release_m(0);
    tick();
    chk("burst_idle", gnt_o, 2'b00);

    // Watchdog: slave never answers m0
    set_m(0, 1'b1, 1'b1, 32'h900, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      chk("wd_no_tout", tout_o, 1'b0);
      chk("wd_no_err", m0_err_o, 1'b0);
      chk("wd_cyc", s_cyc_o, 1'b1);
      tick();
    end
    chk("wd_tout", tout_o, 1'b1);
    chk("wd_m0_err", m0_err_o, 1'b1);
    chk("wd_m1_err", m1_err_o, 1'b0);
    chk("wd_s_cyc", s_cyc_o, 1'b0);
    chk("wd_s_stb", s_stb_o, 1'b0);
    $display("xfer: m0 timeout at adr=900");
    set_m(1, 1'b1, 1'b0, 32'hA00, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    s_ack_i = 1'b1;
    #1;
    chk("tout_drop_ack0", m0_ack_o, 1'b0);
    chk("tout_drop_ack1", m1_ack_o, 1'b0);
    tick();
    s_ack_i = 1'b0;
    chk("tout_pulse_end", tout_o, 1'b0);
    chk("tout_err_end", m0_err_o, 1'b0);
    chk("tout_no_regrant", s_cyc_o, 1'b0);
    release_m(0);
    tick();
    chk("tout_to_idle", gnt_o, 2'b00);
    tick();
    chk("tout_m1_gnt", gnt_o, 2'b10);
    release_m(1);
    tick();
    chk("tout_m1_idle", gnt_o, 2'b00);

    // Ack arrives in the cycle the watchdog would expire
    set_m(0, 1'b1, 1'b1, 32'hB00, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    sb.push_back('{0, 32'h7777_0007, 1'b0});
    tick();
    for (int i = 0; i < TO - 2; i++) tick();
    respond();
    chk("race_no_tout", tout_o, 1'b0);
    chk("race_no_err", m0_err_o, 1'b0);
    chk("race_gnt", gnt_o, 2'b01);
    release_m(0);
    tick();
    chk("race_idle", gnt_o, 2'b00);

    // Reset in the middle of an m1 burst
    set_m(1, 1'b1, 1'b1, 32'hC00, 1'b0, '0, 4'hF, CTI_INCR, 2'b00);
    tick();
    chk("rstb_gnt", gnt_o, 2'b10);
    sb.push_back('{1, 32'h4444_0000, 1'b0});
    respond();
    set_m(1, 1'b1, 1'b1, 32'hC04, 1'b0, '0, 4'hF, CTI_INCR, 2'b00);
    #1;
    chk("rstb_cyc_before", s_cyc_o, 1'b1);
    wb_rst = 1'b1;
    tick();
    chk("rstb_s_cyc", s_cyc_o, 1'b0);
    chk("rstb_s_stb", s_stb_o, 1'b0);
    chk("rstb_gnt0", gnt_o, 2'b00);
    s_ack_i = 1'b1;
    #1;
    chk("rstb_no_ack", m1_ack_o, 1'b0);
    s_ack_i = 1'b0;
    release_m(1);
    wb_rst = 1'b0;
    tick();
    set_m(0, 1'b1, 1'b1, 32'hD00, 1'b0, '0, 4'hF, CTI_CLASSIC, 2'b00);
    sb.push_back('{0, 32'h5555_0000, 1'b0});
    tick();
    chk("post_rst_gnt", gnt_o, 2'b01);
    chk("post_rst_adr", s_adr_o, 32'hD00);
    respond();
    release_m(0);
    tick();
    chk("post_rst_idle", gnt_o, 2'b00);

    chk("sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_mem_arbiter.md
# wb_mem_arbiter

Arbitrates the single WISHBONE memory port between the Ethernet MAC's two bus masters: requester 0 (RX DMA write-back) and requester 1 (TX DMA fetch). The grant is held for a whole WISHBONE cycle, `cyc` high to `cyc` low, so classic and incrementing bursts (`cti`/`bte`) are never split. A per-transfer watchdog terminates a hung slave access with an error. The block sits between the MAC master ports and the memory-side `m_wb_*` signal group.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width; select width is `DW/8`
- `TIMEOUT`, 256, cycles `s_stb_o` may wait for ack/err before forced termination; range 2..65535

Ports:
- `wb_clk` in 1 — single clock; all logic on the rising edge
- `wb_rst` in 1 — reset, synchronous, active-high
- `m0_adr_i`, `m1_adr_i` in AW — requester addresses
- `m0_sel_i`, `m1_sel_i` in DW/8 — byte selects
- `m0_we_i`, `m1_we_i` in 1 — write enable
- `m0_dat_i`, `m1_dat_i` in DW — write data
- `m0_cyc_i`, `m1_cyc_i` in 1 — cycle request; this is the arbitration request
- `m0_stb_i`, `m1_stb_i` in 1 — strobe
- `m0_cti_i`, `m1_cti_i` in 3 — cycle type identifier
- `m0_bte_i`, `m1_bte_i` in 2 — burst type extension
- `m0_dat_o`, `m1_dat_o` out DW — read data, driven directly from `s_dat_i` to both requesters
- `m0_ack_o`, `m1_ack_o` out 1 — acknowledge, routed to the owner only
- `m0_err_o`, `m1_err_o` out 1 — error, routed to the owner only; also carries the timeout error
- `s_adr_o` out AW, `s_sel_o` out DW/8, `s_we_o` out 1, `s_dat_o` out DW, `s_cyc_o` out 1, `s_stb_o` out 1, `s_cti_o` out 3, `s_bte_o` out 2 — memory-side master outputs
- `s_dat_i` in DW, `s_ack_i` in 1, `s_err_i` in 1 — memory-side responses
- `gnt_o` out 2 — one-hot current owner; `00` when idle
- `tout_o` out 1 — one-cycle pulse when the watchdog fires

## Operation
FSM states: `IDLE`, `GNT0`, `GNT1`, `TOUT`.
- `IDLE`:
  - only `mX_cyc_i` high → `GNTX`.
  - both high → grant the requester not served last; `last` register resets to 1, so m0 wins the first tie.
- `GNTX`:
  - all `s_*` outputs are combinationally muxed from requester X.
  - `mX_ack_o = s_ack_i` and `mX_err_o = s_err_i`; the other requester's ack/err are forced 0.
  - `last <= X`.
- Exit from `GNTX` when `mX_cyc_i` is sampled low:
  - other requester's `cyc` high → go directly to that requester's grant state (back-to-back, no idle cycle).
  - otherwise → `IDLE`.
- Watchdog:
  - 16-bit counter increments each cycle `s_stb_o && !s_ack_i && !s_err_i`.
  - cleared on ack, err, or `stb` low.
  - when it reaches `TIMEOUT-1` without a response → `TOUT`.
- `TOUT`:
  - `s_cyc_o`/`s_stb_o` forced 0.
  - owner's `err_o` and `tout_o` pulse in the first `TOUT` cycle only.
  - stay until the owner drops `cyc`, then `IDLE`. Re-arbitration is not allowed while the owner still holds `cyc`.
- In `IDLE` and `TOUT`, all `s_*` outputs are 0.

## Timing
- Reset values: FSM `IDLE`, `last`=1, counter 0. All outputs 0 except `mX_dat_o`, which follow `s_dat_i`.
- Grant latency: `cyc` asserted at edge N → state is `GNTX` after edge N+1 → `s_cyc_o` high in cycle N+1.
- Once granted, the data path adds zero latency: ack/err pass through combinationally in the same cycle.
- Ack/err and watchdog expiry in the same cycle: the response wins, the counter clears, and there is no timeout.
- Burst: the grant holds across `cti`=010 beats through `cti`=111; `cti`/`bte` pass through unmodified.
- Owner drops `cyc` in the same cycle as a response: the response is still delivered, then hand-over occurs.
- `wb_rst` sampled high mid-transfer: `IDLE` after that edge, `s_cyc_o` low immediately, no ack/err forwarded.
- Responses arriving in `IDLE`/`TOUT` are dropped.

## Structure
- Package `wb_arb_pkg`:
  - `arb_state_t` enum.
  - CTI constants: `CTI_CLASSIC`=000, `CTI_INCR`=010, `CTI_EOB`=111.
  - Default `AW`/`DW`.
- Sub-module `wb_arb_watchdog`: parameter `TIMEOUT`; inputs `stb`, `ack`, `err`; output `expire`.

## Test plan
- Single m0 classic read at 0x100, slave acks after 3 cycles: `s_cyc_o` rises 1 cycle after `m0_cyc_i`; `m0_ack_o` pulses once with data; `m1_ack_o` stays 0.
- Both `cyc` raised in the same cycle after reset: m0 granted first; m1 granted on the cycle after m0 drops `cyc`, with no `IDLE` gap; next tie goes to m0 again.
- m1 4-beat incrementing burst (`cti` 010,010,010,111) while m0 requests: m0 stays blocked until after the 4th ack and m1 `cyc` low.
- `TIMEOUT`=8, slave never acks m0: after 7 wait cycles, `m0_err_o` and `tout_o` pulse once and `s_cyc_o` drops; `IDLE` when `m0_cyc_i` falls.
- Ack on the same cycle the watchdog would expire: no `tout_o`, normal ack delivered.
- `wb_rst` asserted mid-burst of m1: outputs 0 after the edge; after release, a new m0 request is granted normally.
